// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM state encoding, counter
// widths and the key-to-matrix lookup tables.
package keypad_pkg;

  localparam int CNT_W = 24;
  localparam int TOG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HOLD,
    ST_RELEASE_BOUNCE,
    ST_GAP
  } kp_state_e;

  // Indexed by key code; entry 0 is the rightmost element.
  // Column one-hot: bit3 = keys 1,4,7,0; bit2 = 2,5,8,F; bit1 = 3,6,9,E; bit0 = A,B,C,D.
  localparam logic [15:0][3:0] KEY_COL_TBL = {
    4'h4, 4'h2, 4'h1, 4'h1,
    4'h1, 4'h1, 4'h2, 4'h4,
    4'h8, 4'h2, 4'h4, 4'h8,
    4'h2, 4'h4, 4'h8, 4'h8
  };

  // Row one-hot: bit3 = R1 ... bit0 = R4.
  localparam logic [15:0][3:0] KEY_ROW_TBL = {
    4'h1, 4'h1, 4'h1, 4'h2,
    4'h4, 4'h8, 4'h2, 4'h2,
    4'h2, 4'h4, 4'h4, 4'h4,
    4'h8, 4'h8, 4'h8, 4'h1
  };

endpackage

// File: rtl/keypad_key_map.sv
// Combinational key code to (column, row) one-hot lookup; usable on either
// side of the matrix.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] key_code_i,
  output logic [3:0] col_onehot_o,
  output logic [3:0] row_onehot_o
);

  assign col_onehot_o = KEY_COL_TBL[key_code_i];
  assign row_onehot_o = KEY_ROW_TBL[key_code_i];

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one 4x4 matrix keypad switch: accepts a key code, then plays a
// press bounce / hold / release bounce / gap sequence onto the Row lines.
//   state             | meaning
//   ST_IDLE           | ready for a key, contact open
//   ST_PRESS_BOUNCE   | contact toggling after press, starts closed
//   ST_HOLD           | contact closed for HOLD_CYCLES
//   ST_RELEASE_BOUNCE | contact toggling after release, starts open
//   ST_GAP            | contact open for GAP_CYCLES
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 200000,
  parameter int unsigned GAP_CYCLES    = 200000,
  parameter int unsigned BOUNCE_PERIOD = 64,
  parameter int unsigned BOUNCE_COUNT  = 4
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic       contact
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [TOG_W-1:0] LAST_TOG  = TOG_W'(BOUNCE_COUNT - 1);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic             contact_q, contact_d;
  logic             ready_q, ready_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       map_col, map_row;

  keypad_key_map u_key_map (
    .key_code_i   (code_d),
    .col_onehot_o (map_col),
    .row_onehot_o (map_row)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tog_d     = tog_q;
    contact_d = contact_q;
    ready_d   = ready_q;
    code_d    = code_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (key_valid && ready_q) begin
          code_d    = key_code;
          ready_d   = 1'b0;
          contact_d = 1'b1;
          tog_d     = '0;
          if (BOUNCE_COUNT == 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_PRESS_BOUNCE;
            cnt_d   = PERIOD_LD;
          end
        end
      end
      ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
        if (cnt_q == '0) begin
          // BOUNCE_COUNT is even, so the final toggle lands on the next phase's level.
          contact_d = ~contact_q;
          if (tog_q == LAST_TOG) begin
            tog_d = '0;
            if (state_q == ST_PRESS_BOUNCE) begin
              state_d = ST_HOLD;
              cnt_d   = HOLD_LD;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            tog_d = tog_q + TOG_W'(1);
            cnt_d = PERIOD_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          contact_d = 1'b0;
          tog_d     = '0;
          if (BOUNCE_COUNT == 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = ST_RELEASE_BOUNCE;
            cnt_d   = PERIOD_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Row follows the next contact level so it never lags a contact change.
  always_comb begin
    row_d = 4'hF;
    if (contact_d && ((Col & map_col) == 4'h0)) row_d = ~map_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      contact_q <= 1'b0;
      ready_q   <= 1'b0;
      code_q    <= 4'h0;
      row_q     <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      code_q    <= code_d;
      row_q     <= row_d;
    end
  end

  assign key_ready = ready_q;
  assign busy      = ~ready_q;
  assign contact   = contact_q;
  assign Row       = row_q;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter: HOLD_CYCLES, default 200000, cycles the contact stays closed after press bounce; legal range 1..2^24-1.
REQ-002 Parameter: GAP_CYCLES, default 200000, cycles the contact stays open after release bounce; legal range 1..2^24-1.
REQ-003 Parameter: BOUNCE_PERIOD, default 64, cycles between contact toggles during bounce; legal range 1..2^16-1.
REQ-004 Parameter: BOUNCE_COUNT, default 4, toggles per bounce phase; must be even, 0 disables bounce.
REQ-005 Port: clk  input  1  single clock for all logic.
REQ-006 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-007 Port: key_code  input  4  hex key to press (0x0-0xF).
REQ-008 Port: key_valid  input  1  key_code is offered.
REQ-009 Port: key_ready  output  1  emulator can accept a key.
REQ-010 Port: Col  input  4  active-low column drive from the scanner.
REQ-011 Port: Row  output  4  active-low row response to the scanner.
REQ-012 Port: busy  output  1  press/release sequence in progress.
REQ-013 Port: contact  output  1  emulated switch closed (debug).

Function
REQ-014 Key map, stated as Col bit low -> Row bit low: Col 0111 = keys 1,4,7,0; Col 1011 = keys 2,5,8,F; Col 1101 = keys 3,6,9,E; Col 1110 = keys A,B,C,D; each listed in row order R1..R4, with Row 0111/1011/1101/1110.
REQ-015 Row is registered and reflects the Col value sampled on the previous edge (1-cycle latency).
REQ-016 Row bit for the latched key is 0 iff contact=1 and that key's Col bit is 0; all other Row bits are 1.
REQ-017 Row is 1111 whenever contact=0.
REQ-018 If several Col bits are low, Row still follows REQ-016 (wired-AND behaviour).
REQ-019 States: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
REQ-020 key_ready=1 only in IDLE; busy = !key_ready.
REQ-021 Handshake: on an edge with key_valid=1 and key_ready=1, key_code is latched and the FSM leaves IDLE the same edge.
REQ-022 key_valid while key_ready=0 is ignored, with no queuing.
REQ-023 After acceptance, the FSM enters PRESS_BOUNCE, or HOLD directly if BOUNCE_COUNT=0.
REQ-024 PRESS_BOUNCE behaviour:
- contact=1 on entry, toggles every BOUNCE_PERIOD cycles;
- after BOUNCE_COUNT toggles, transitions to HOLD.
REQ-025 In HOLD, contact=1 for exactly HOLD_CYCLES cycles, then the FSM enters RELEASE_BOUNCE, or GAP if BOUNCE_COUNT=0.
REQ-026 RELEASE_BOUNCE behaviour:
- contact=0 on entry, toggles every BOUNCE_PERIOD cycles;
- after BOUNCE_COUNT toggles, transitions to GAP.
REQ-027 In GAP, contact=0 for exactly GAP_CYCLES cycles, then the FSM returns to IDLE.
REQ-028 One shared 24-bit down-counter times all phases; it is reloaded on every state entry.
REQ-029 key_code latch is stable from acceptance until IDLE; input changes after acceptance have no effect.

Reset
REQ-030 While rst_n=0, regardless of state:
- FSM=IDLE, contact=0, Row=1111;
- key_ready=0, busy=1, counters=0, latched code=0.
REQ-031 On the first edge after rst_n deasserts, key_ready=1 and busy=0.
REQ-032 Reset mid-sequence abandons the key with no completion.

Structure
REQ-033 Shared package keypad_pkg holds:
- state enum;
- key-to-column and key-to-row one-hot constant tables;
- counter width constants.
REQ-034 One sub-module, keypad_key_map: combinational key_code -> (col_onehot, row_onehot) lookup, also reusable by scanner-side logic.

Verification (HOLD=1000, GAP=500, BOUNCE_PERIOD=10, BOUNCE_COUNT=4)
REQ-035 Send key 5, then in HOLD drive Col=1011 -> Row=1011 one edge later; Col=0111 -> Row=1111.
REQ-036 Send key 5 and pulse key_valid with key 9 during HOLD -> key 9 is ignored; key_ready stays 0 for 40+1000+40+500 cycles after acceptance, then returns to 1.
REQ-037 Send key A, monitor contact -> 1,0,1,0 at 10-cycle steps, then 1 for 1000 cycles, then 0,1,0,1 at 10-cycle steps, then 0 for 500 cycles.
REQ-038 Assert rst_n=0 mid-HOLD with Col=1110 and key D -> Row=1111 and contact=0 immediately; key_ready=1 one edge after release.
REQ-039 Sweep all 16 codes with a rotating Col scan -> exactly one Row bit low, only in the correct column slot per REQ-014.
REQ-040 With BOUNCE_COUNT=0, send key F -> contact rises the edge after acceptance and stays 1 for exactly 1000 cycles.
